// File: rtl/regfile_mp_sb_if.sv
// Register-file port bundle: write/read ports, issue and the scoreboard vector.
// The pipeline drives the master side and the register file is the slave side.
interface regfile_mp_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1
);
  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_WR-1:0]            we;
  logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WR*DATA_WIDTH-1:0] wdata;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rpend;
  logic                         issue_valid;
  logic [ADDR_WIDTH-1:0]        issue_addr;
  logic [NUM_REGS-1:0]          pending;

  modport master (
    output we, waddr, wdata, raddr, issue_valid, issue_addr,
    input  rdata, rpend, pending
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue_valid, issue_addr,
    output rdata, rpend, pending
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-ported integer register file with x0 hardwired to zero, optional
// same-cycle write bypass and a per-register pending (scoreboard) bit.
module regfile_mp_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic           clk,
  input  logic           async_rst_n,
  regfile_mp_sb_if.slave rf
);
  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   pend_q;

  logic [ADDR_WIDTH-1:0] wa [NUM_WR];
  logic [DATA_WIDTH-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0]     wv;
  logic [ADDR_WIDTH-1:0] ra [NUM_RD];

  // Unpack the flat port buses; a write to x0 is never effective.
  always_comb begin
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wa[p] = rf.waddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wd[p] = rf.wdata[p*DATA_WIDTH +: DATA_WIDTH];
      wv[p] = rf.we[p] && (rf.waddr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0);
    end
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      ra[r] = rf.raddr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Ascending port order makes the highest-index writer win; issue is last so set beats clear.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[ADDR_WIDTH'(i)] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wv[p]) begin
          regs_q[wa[p]] <= wd[p];
          pend_q[wa[p]] <= 1'b0;
        end
      end
      if (rf.issue_valid && (rf.issue_addr != '0)) begin
        pend_q[rf.issue_addr] <= 1'b1;
      end
    end
  end

  logic [NUM_RD*DATA_WIDTH-1:0] rdata_c;
  logic [NUM_RD-1:0]            rpend_c;

  // Combinational read with optional forwarding from this cycle's writers.
  always_comb begin
    rdata_c = '0;
    rpend_c = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      if (ra[r] != '0) begin
        rdata_c[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra[r]];
        rpend_c[r] = pend_q[ra[r]];
        if (BYPASS != 0) begin
          for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wv[p] && (wa[p] == ra[r])) begin
              rdata_c[r*DATA_WIDTH +: DATA_WIDTH] = wd[p];
              rpend_c[r] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign rf.rdata   = rdata_c;
  assign rf.rpend   = rpend_c;
  assign rf.pending = pend_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a dual-write bypassing instance and a
// single-write instance without bypass, sharing clock and reset.
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic async_rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) ifa ();
  regfile_mp_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(1)) ifb ();

  regfile_mp_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
    .clk(clk), .async_rst_n(async_rst_n), .rf(ifa.slave)
  );
  regfile_mp_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) dut_b (
    .clk(clk), .async_rst_n(async_rst_n), .rf(ifb.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.we = '0; ifa.waddr = '0; ifa.wdata = '0; ifa.raddr = '0;
    ifa.issue_valid = 1'b0; ifa.issue_addr = '0;
    ifb.we = '0; ifb.waddr = '0; ifb.wdata = '0; ifb.raddr = '0;
    ifb.issue_valid = 1'b0; ifb.issue_addr = '0;

    // reset state
    #2;
    ifa.raddr = {5'd1, 5'd5};
    #1;
    chk("rst_rdata_a", 64'(ifa.rdata), 64'h0);
    chk("rst_rpend_a", 64'(ifa.rpend), 64'h0);
    chk("rst_pend_a", 64'(ifa.pending), 64'h0);
    chk("rst_pend_b", 64'(ifb.pending), 64'h0);
    tick();
    async_rst_n = 1'b1;
    tick();

    // basic write/read and x0 (port0 -> x1, port1 -> x0)
    ifa.we = 2'b11; ifa.waddr = {5'd0, 5'd1}; ifa.wdata = {32'hFFFFFFFF, 32'h12345678};
    ifa.raddr = {5'd0, 5'd1};
    #1;
    chk("byp_x1", 64'(ifa.rdata[31:0]), 64'h12345678);
    chk("byp_x0", 64'(ifa.rdata[63:32]), 64'h0);
    tick();
    ifa.we = '0;
    #1;
    chk("rd_x1", 64'(ifa.rdata[31:0]), 64'h12345678);
    chk("rd_x0", 64'(ifa.rdata[63:32]), 64'h0);
    chk("rpend_x0", 64'(ifa.rpend[1]), 64'h0);
    chk("pend0", 64'(ifa.pending[0]), 64'h0);

    // dual-write collision on x7: port1 wins
    ifa.we = 2'b11; ifa.waddr = {5'd7, 5'd7}; ifa.wdata = {32'h0000BBBB, 32'hAAAA0000};
    ifa.raddr = {5'd1, 5'd7};
    #1;
    chk("coll_byp", 64'(ifa.rdata[31:0]), 64'h0000BBBB);
    tick();
    ifa.we = '0;
    #1;
    chk("coll_store", 64'(ifa.rdata[31:0]), 64'h0000BBBB);

    // bypass versus no bypass on x3
    ifa.we = 2'b01; ifa.waddr = {5'd0, 5'd3}; ifa.wdata = {32'h0, 32'h55};
    ifa.raddr = {5'd0, 5'd3};
    ifb.we = 1'b1; ifb.waddr = 5'd3; ifb.wdata = 32'h55; ifb.raddr = {5'd0, 5'd3};
    #1;
    chk("x3_byp_a", 64'(ifa.rdata[31:0]), 64'h55);
    chk("x3_old_b", 64'(ifb.rdata[31:0]), 64'h0);
    tick();
    ifa.we = '0; ifb.we = '0;
    #1;
    chk("x3_new_b", 64'(ifb.rdata[31:0]), 64'h55);

    // scoreboard life cycle on x10, both instances
    ifa.issue_valid = 1'b1; ifa.issue_addr = 5'd10; ifa.raddr = {5'd3, 5'd10};
    ifb.issue_valid = 1'b1; ifb.issue_addr = 5'd10; ifb.raddr = {5'd3, 5'd10};
    #1;
    chk("iss_not_yet", 64'(ifa.rpend[0]), 64'h0);
    tick();
    ifa.issue_valid = 1'b0; ifb.issue_valid = 1'b0;
    #1;
    chk("rpend_x10_a", 64'(ifa.rpend[0]), 64'h1);
    chk("pend_vec_a", 64'(ifa.pending), 64'h0000_0400);
    chk("rpend_x10_b", 64'(ifb.rpend[0]), 64'h1);
    ifa.we = 2'b01; ifa.waddr = {5'd0, 5'd10}; ifa.wdata = {32'h0, 32'h99};
    ifb.we = 1'b1; ifb.waddr = 5'd10; ifb.wdata = 32'h99;
    #1;
    chk("wb_rpend_a", 64'(ifa.rpend[0]), 64'h0);
    chk("wb_rdata_a", 64'(ifa.rdata[31:0]), 64'h99);
    chk("wb_rpend_b", 64'(ifb.rpend[0]), 64'h1);
    tick();
    ifa.we = '0; ifb.we = '0;
    #1;
    chk("pend10_clr_a", 64'(ifa.pending[10]), 64'h0);
    chk("pend10_clr_b", 64'(ifb.rpend[0]), 64'h0);
    ifa.issue_valid = 1'b1; ifa.issue_addr = 5'd0;
    tick();
    ifa.issue_valid = 1'b0;
    #1;
    chk("iss_x0", 64'(ifa.pending), 64'h0);

    // simultaneous issue and writeback on x4: set wins
    ifa.issue_valid = 1'b1; ifa.issue_addr = 5'd4; ifa.raddr = {5'd3, 5'd4};
    tick();
    ifa.issue_valid = 1'b0;
    #1;
    chk("pend4_set", 64'(ifa.pending[4]), 64'h1);
    ifa.issue_valid = 1'b1; ifa.issue_addr = 5'd4;
    ifa.we = 2'b10; ifa.waddr = {5'd4, 5'd0}; ifa.wdata = {32'h7, 32'h0};
    tick();
    ifa.issue_valid = 1'b0; ifa.we = '0;
    #1;
    chk("pend4_kept", 64'(ifa.pending[4]), 64'h1);
    chk("x4_data", 64'(ifa.rdata[31:0]), 64'h7);
    chk("x4_rpend", 64'(ifa.rpend[0]), 64'h1);

    // mid-cycle asynchronous reset
    ifa.we = 2'b01; ifa.waddr = {5'd0, 5'd5}; ifa.wdata = {32'h0, 32'hDEADBEEF};
    ifa.raddr = {5'd4, 5'd5};
    tick();
    ifa.we = '0;
    #1;
    chk("x5_stored", 64'(ifa.rdata[31:0]), 64'hDEADBEEF);
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("arst_x5", 64'(ifa.rdata[31:0]), 64'h0);
    chk("arst_pend", 64'(ifa.pending), 64'h0);
    chk("arst_rpend", 64'(ifa.rpend), 64'h0);
    chk("arst_b", 64'(ifb.rdata[31:0]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
